// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Bundles the start/busy/done handshake, the operands and the results of the
// sequential divider.
//
// Handshake: the requester raises start together with dividend/divisor.
// The divider samples them on a rising CLK edge only while it is idle, and
// busy rises on that same edge. While busy is high, start is ignored and
// the operands are not looked at again. done is a one-cycle pulse. When it
// is high, quotient, remainder and div_by_zero are valid, and they stay
// unchanged until the next accepted start.
//
// Signals
//   start        master -> slave  request, accepted only when idle
//   dividend     master -> slave  numerator, WIDTH bits
//   divisor      master -> slave  denominator, WIDTH bits
//   busy         slave -> master  operation in progress (RUN or DONE)
//   done         slave -> master  one-cycle result strobe
//   div_by_zero  slave -> master  last accepted divisor was zero
//   quotient     slave -> master  result, WIDTH bits
//   remainder    slave -> master  result, WIDTH bits
//   dbg_state    slave -> master  current FSM state, for observation only
// -----------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [1:0]       dbg_state;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, dbg_state
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, dbg_state
    );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Restoring shift-subtract divider for unsigned WIDTH-bit operands. It
// produces one quotient bit per clock. An accepted start with a non-zero
// divisor gives done WIDTH+1 edges after acceptance. A zero divisor gives
// done one edge after acceptance, with quotient = all ones and
// remainder = dividend.
//
// Ports
//   CLK  system clock, rising edge
//   RST  asynchronous, active-high reset
//   bus  seq_divider_if.slave : start/operands in; busy/done/results and
//        debug state out
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    seq_divider_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // R always stays below D, so WIDTH bits hold it between iterations.
    // The shifted value and the subtractor are WIDTH+1 bits wide.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_shift;

    always_comb begin
        // The dividend MSB enters R on the first shift and is not lost.
        r_shift = {r_q, q_q[WIDTH-1]};
        q_shift = q_q << 1;
        trial   = r_shift - {1'b0, d_q};

        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.divisor != '0) begin
                        r_d     = '0;
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end

            S_RUN: begin
                // A set borrow bit means the trial went negative, so keep
                // the shifted R (restore) and record a 0 quotient bit.
                if (!trial[WIDTH]) begin
                    r_d = trial[WIDTH-1:0];
                    q_d = q_shift | WIDTH'(1);
                end else begin
                    r_d = r_shift[WIDTH-1:0];
                    q_d = q_shift;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Drives seq_divider through directed and randomized divisions. Every result
// is compared against plain integer division done inside the bench.
// -----------------------------------------------------------------------------
module tb_seq_divider;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (dif)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W:0] exp_q[$];   // {div_by_zero, quotient, remainder}

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0)
            return {1'b1, {W{1'b1}}, a};
        return {1'b0, a / b, a % b};
    endfunction

    // ---------------- drivers ----------------
    // One division. If inj is non-zero, a 7/7 request is presented on that
    // cycle after acceptance. The divider must ignore it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        logic [2*W:0] e;
        logic [W-1:0] q_seen;
        logic [W-1:0] r_seen;
        int cyc;
        int busy_cnt;
        int exp_lat;
        logic seen;
        exp_q.push_back(model(a, b));
        exp_lat = (b == 0) ? 1 : LAT;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && cyc < LAT + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == inj) begin
                dif.start    = 1'b1;
                dif.dividend = 7;
                dif.divisor  = 7;
            end else begin
                // Scramble the operands so that any resampling shows up.
                dif.start    = 1'b0;
                dif.dividend = $urandom;
                dif.divisor  = $urandom;
            end
            if (dif.busy) busy_cnt++;
            if (dif.done) seen = 1'b1;
        end
        e = exp_q.pop_front();
        check("done_seen", W'(seen), W'(1));
        check("latency", W'(cyc), W'(exp_lat));
        check("busy_cycles", W'(busy_cnt), W'(exp_lat));
        check("quotient", dif.quotient, e[2*W-1:W]);
        check("remainder", dif.remainder, e[W-1:0]);
        check("div_by_zero", W'(dif.div_by_zero), W'(e[2*W]));
        q_seen = dif.quotient;
        r_seen = dif.remainder;
        @(negedge clk);
        dif.start = 1'b0;
        check("done_one_cycle", W'(dif.done), W'(0));
        check("busy_after_done", W'(dif.busy), W'(0));
        check("quotient_held", dif.quotient, q_seen);
        check("remainder_held", dif.remainder, r_seen);
    endtask

    // Start a division, then reset between edges on cycle rst_at.
    task automatic do_abort(input logic [W-1:0] a, input logic [W-1:0] b, input int rst_at);
        logic seen;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        for (int i = 0; i < rst_at; i++) begin
            @(negedge clk);
            dif.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_busy", W'(dif.busy), W'(0));
        check("abort_done", W'(dif.done), W'(0));
        check("abort_dbz", W'(dif.div_by_zero), W'(0));
        check("abort_quotient", dif.quotient, W'(0));
        check("abort_remainder", dif.remainder, W'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (dif.done) seen = 1'b1;
        end
        check("abort_no_done", W'(seen), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        #1;
        check("rst_busy", W'(dif.busy), W'(0));
        check("rst_done", W'(dif.done), W'(0));
        check("rst_dbz", W'(dif.div_by_zero), W'(0));
        check("rst_quotient", dif.quotient, W'(0));
        check("rst_remainder", dif.remainder, W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(100, 7, 0);
        do_op(32'hFFFF_FFFF, 1, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3, 10, 0);
        do_op(32'h8000_0000, 3, 0);
        do_op(5, 0, 1);              // extra request lands in DONE
        do_op(9, 2, 0);
        do_op(50, 5, 10);            // extra request lands in RUN
        do_op(50, 5, LAT);           // extra request lands in DONE
        do_abort(1000, 3, 15);
        do_op(1000, 3, 0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: begin a = W'($urandom_range(0, 1000)); b = a + W'($urandom_range(1, 1000)); end
                3: b = $urandom;
                default: b = W'($urandom_range(1, 65535));
            endcase
            do_op(a, b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
